a2d_round_robin: RTL and testbench
==================================

# a2d_round_robin

Upstream analog front end for sensor conditioning: a free-running scheduler plus SPI master that converts the battery, current, brake and torque channels of the external 8-channel 12-bit A2D in fixed round-robin order. Each channel's latest conversion is held in its own 12-bit register, which sensor conditioning consumes directly (`batt`, `curr`, `torque`; `brake` goes to the brake logic). One conversion starts every `CONV_PERIOD` clocks. Each conversion is two 16-bit SPI frames: a command frame, then a read frame.

## Interface
- `CONV_PERIOD`, 16384: clocks between conversion starts; must be ≥ 34*`SCLK_DIV`.
- `SCLK_DIV`, 32: clk cycles per SCLK period; even, ≥ 4.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `MISO`  in  1  serial data from A2D.
- `SS_n`  out  1  A2D slave select, active low.
- `SCLK`  out  1  SPI clock, idle low (mode 0).
- `MOSI`  out  1  serial data to A2D.
- `batt`  out  12  latest channel-0 result.
- `curr`  out  12  latest channel-1 result.
- `brake`  out  12  latest channel-3 result.
- `torque`  out  12  latest channel-4 result.
- `conv_done`  out  1  one-clock pulse when a result register updates.

## Operation
- Period timer counts 0..`CONV_PERIOD`-1 and wraps. It runs continuously, including during transactions. Each wrap to 0 issues a start.
- Slot index is 2 bits, 0..3, wrapping 3→0. Slot→channel/register mapping: 0→ch0/`batt`, 1→ch1/`curr`, 2→ch3/`brake`, 3→ch4/`torque`. The index advances only on completion.
- FSM states: IDLE, FRAME1, GAP, FRAME2, DONE.
  - IDLE→FRAME1 on start.
  - FRAME1→GAP after 16 bits.
  - GAP→FRAME2 after `SCLK_DIV` clocks.
  - FRAME2→DONE after 16 bits.
  - DONE→IDLE after one clock.
  - A start arriving outside IDLE is ignored; this cannot happen with legal parameters.
- FRAME1 MOSI word: {2'b00, ch[2:0], 11'h000}, MSB first. MISO during FRAME1 is discarded.
- FRAME2 MOSI word: 16'h0000. All 16 MISO bits are shifted in MSB first. The result is rx[11:0]; rx[15:12] is ignored.
- In DONE: the selected register loads the result, `conv_done`=1, and the slot index increments. The other three registers hold.
- SPI bit timing within a frame, with H = `SCLK_DIV`/2 and T = clock where SS_n goes low:
  - MOSI carries bit 15 from T.
  - SCLK rises at T+H, T+3H, …, T+31H and falls at T+2H, …, T+32H.
  - MISO is sampled on the clk edge where SCLK goes 0→1.
  - MOSI shifts to the next bit on the edge where SCLK goes 1→0.
  - SS_n returns high at T+32H with SCLK low.
- SS_n stays high throughout GAP. MOSI is 0 whenever SS_n is high.

## Timing
- Reset values: `SS_n`=1, `SCLK`=0, `MOSI`=0, all four results 12'h000, `conv_done`=0, slot=0, timer=0, state IDLE.
- First start fires on the wrap that occurs `CONV_PERIOD` clocks after `rst` deasserts.
  - SS_n falls on the clock after the start.
- Each frame keeps SS_n low for 16*`SCLK_DIV` clocks. GAP lasts `SCLK_DIV` clocks.
- `conv_done` pulses, and the register updates, one clock after SS_n rises at the end of FRAME2.
- Latency from SS_n fall (FRAME1) to `conv_done` = 33*`SCLK_DIV`+1 clocks (1057 with defaults).
- Result registers change only in DONE. Consumers may sample them on any clock.
- `rst` asserted mid-transaction aborts on that edge:
  - outputs return to their reset values on the next clock;
  - no partial result is written;
  - slot returns to 0.

## Test plan
- Post-reset idle: hold `rst` for 5 clocks, release → all outputs at reset values; SS_n stays 1 for exactly `CONV_PERIOD` clocks, then falls on the next clock.
- Command encoding: SPI slave model decodes each FRAME1 word → 0x0000, 0x0800, 0x1800, 0x2000 in sequence, then 0x0000 again on the fifth conversion.
- Result routing:
  - Slave returns 0xFABC for ch0, 0x0123 for ch1, 0x0ABC for ch3, 0x0FFF for ch4.
  - Expected: `batt`=0xABC, `curr`=0x123, `brake`=0xABC, `torque`=0xFFF.
  - Each update coincides with a single-cycle `conv_done`; the other registers are unchanged at that edge.
- SPI waveform: `SCLK_DIV`=32.
  - SCLK high 16 / low 16 clocks; 16 rising edges per frame.
  - SS_n low 512 clocks per frame with a 32-clock high gap; `conv_done` pulses 1057 clocks after the first SS_n fall.
  - MOSI is stable at every SCLK rise.
- Reset mid-FRAME2: assert `rst` after the 8th SCLK rise → SS_n=1 and SCLK=0 next clock; `batt` stays 0x000; the next conversion after release uses ch0.
- Back-to-back periods, `CONV_PERIOD`=1100, 16 conversions:
  - no start is lost;
  - starts are exactly 1100 clocks apart;
  - slot sequence is 0,1,2,3 repeating;
  - SS_n is never low across a period boundary it did not start in.

Source files
------------

// File: rtl/a2d_round_robin.sv
// Round-robin A2D scheduler and SPI master: converts channels 0,1,3,4 of an external
// 12-bit A2D once per CONV_PERIOD clocks and holds each latest result.
module a2d_round_robin #(
  parameter int unsigned CONV_PERIOD = 16384,
  parameter int unsigned SCLK_DIV    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MISO,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        conv_done
);

  localparam int unsigned TmrW = $clog2(CONV_PERIOD);
  localparam int unsigned PhW  = $clog2(SCLK_DIV);

  localparam logic [TmrW-1:0] TmrLast = TmrW'(CONV_PERIOD - 1);
  localparam logic [PhW-1:0]  PhLast  = PhW'(SCLK_DIV - 1);
  localparam logic [PhW-1:0]  PhRise  = PhW'(SCLK_DIV / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFrame1,
    StGap,
    StFrame2,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            start_q, start_d;
  logic [1:0]      slot_q, slot_d;
  logic [PhW-1:0]  ph_q, ph_d;
  logic [3:0]      bit_q, bit_d;
  logic            ss_n_q, ss_n_d;
  logic            sclk_q, sclk_d;
  logic [15:0]     tx_q, tx_d;
  // Only the low 12 received bits survive 16 shifts, which is exactly the result field.
  logic [11:0]     rx_q, rx_d;
  logic [11:0]     batt_q, batt_d;
  logic [11:0]     curr_q, curr_d;
  logic [11:0]     brake_q, brake_d;
  logic [11:0]     torque_q, torque_d;
  logic            done_q, done_d;
  logic [2:0]      ch;

  always_comb begin
    ch = 3'd0;
    unique case (slot_q)
      2'd0: ch = 3'd0;
      2'd1: ch = 3'd1;
      2'd2: ch = 3'd3;
      2'd3: ch = 3'd4;
      default: ch = 3'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    ss_n_d   = ss_n_q;
    sclk_d   = sclk_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    batt_d   = batt_q;
    curr_d   = curr_q;
    brake_d  = brake_q;
    torque_d = torque_q;
    done_d   = 1'b0;
    start_d  = (tmr_q == TmrLast);
    tmr_d    = (tmr_q == TmrLast) ? '0 : tmr_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start_q) begin
          state_d = StFrame1;
          ss_n_d  = 1'b0;
          sclk_d  = 1'b0;
          ph_d    = '0;
          bit_d   = '0;
          tx_d    = {2'b00, ch, 11'h000};
        end
      end
      StFrame1, StFrame2: begin
        ph_d = ph_q + 1'b1;
        if (ph_q == PhRise) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[10:0], MISO};
        end
        if (ph_q == PhLast) begin
          sclk_d = 1'b0;
          ph_d   = '0;
          bit_d  = bit_q + 1'b1;
          tx_d   = {tx_q[14:0], 1'b0};
          if (bit_q == 4'd15) begin
            ss_n_d  = 1'b1;
            tx_d    = '0;
            state_d = (state_q == StFrame1) ? StGap : StDone;
          end
        end
      end
      StGap: begin
        ph_d = ph_q + 1'b1;
        if (ph_q == PhLast) begin
          state_d = StFrame2;
          ss_n_d  = 1'b0;
          ph_d    = '0;
          bit_d   = '0;
          tx_d    = '0;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        slot_d  = slot_q + 1'b1;
        state_d = StIdle;
        unique case (slot_q)
          2'd0: batt_d   = rx_q;
          2'd1: curr_d   = rx_q;
          2'd2: brake_d  = rx_q;
          2'd3: torque_d = rx_q;
          default: ;
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      tmr_q    <= '0;
      start_q  <= 1'b0;
      slot_q   <= '0;
      ph_q     <= '0;
      bit_q    <= '0;
      ss_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      batt_q   <= '0;
      curr_q   <= '0;
      brake_q  <= '0;
      torque_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      start_q  <= start_d;
      slot_q   <= slot_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      ss_n_q   <= ss_n_d;
      sclk_q   <= sclk_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      batt_q   <= batt_d;
      curr_q   <= curr_d;
      brake_q  <= brake_d;
      torque_q <= torque_d;
      done_q   <= done_d;
    end
  end

  assign SS_n      = ss_n_q;
  assign SCLK      = sclk_q;
  assign MOSI      = tx_q[15];
  assign batt      = batt_q;
  assign curr      = curr_q;
  assign brake     = brake_q;
  assign torque    = torque_q;
  assign conv_done = done_q;

endmodule

// File: tb/tb_a2d_round_robin.sv
// Directed bench for a2d_round_robin with a mode-0 SPI slave model that answers by channel.
module tb_a2d_round_robin;

  localparam int P   = 1100;
  localparam int DIV = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MISO = 1'b0;
  logic        SS_n, SCLK, MOSI, conv_done;
  logic [11:0] batt, curr, brake, torque;
  logic [47:0] regs;

  int checks = 0;
  int failures = 0;

  a2d_round_robin #(
    .CONV_PERIOD(P),
    .SCLK_DIV   (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .MISO     (MISO),
    .SS_n     (SS_n),
    .SCLK     (SCLK),
    .MOSI     (MOSI),
    .batt     (batt),
    .curr     (curr),
    .brake    (brake),
    .torque   (torque),
    .conv_done(conv_done)
  );

  always #5 clk = ~clk;
  assign regs = {batt, curr, brake, torque};

  // Slave/monitor state, sampled on the falling clock edge.
  int          cyc = 0;
  int          frame_n = 0, done_n = 0, rises = 0, lo_run = 0, hi_run = 0;
  int          sclk_bad = 0, mosi_bad = 0, done_long = 0, stray = 0;
  logic        p_ss = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, p_done = 1'b0;
  logic [47:0] p_regs = '0;
  logic [15:0] mosi_sh = '0, slave_sh = '0;
  logic [2:0]  last_ch = '0;
  int          fall_c [64];
  int          rise_c [64];
  int          nrise  [64];
  logic [15:0] cmd_w  [32];
  int          done_c [32];
  logic [47:0] pre_s  [32];
  logic [47:0] post_s [32];

  function automatic logic [15:0] resp(input logic [2:0] ch);
    case (ch)
      3'd0:    return 16'hFABC;
      3'd1:    return 16'h0123;
      3'd3:    return 16'h0ABC;
      3'd4:    return 16'h0FFF;
      default: return 16'h0000;
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      frame_n = 0; done_n = 0; rises = 0; lo_run = 0; hi_run = 0;
      sclk_bad = 0; mosi_bad = 0; done_long = 0; stray = 0;
      slave_sh = '0; MISO = 1'b0;
    end else begin
      if (p_ss && !SS_n) begin
        if (frame_n < 64) fall_c[frame_n] = cyc;
        rises = 0; lo_run = 0; hi_run = 0;
        // Command frame gets all-ones on MISO, which the DUT must discard.
        slave_sh = (frame_n % 2 == 1) ? resp(last_ch) : 16'hFFFF;
        MISO = slave_sh[15];
      end
      if (!p_sclk && SCLK) begin
        rises++;
        if (lo_run != DIV / 2) sclk_bad++;
        lo_run = 0;
        if (MOSI !== p_mosi) mosi_bad++;
        mosi_sh = {mosi_sh[14:0], MOSI};
      end
      if (p_sclk && !SCLK) begin
        if (hi_run != DIV / 2) sclk_bad++;
        hi_run = 0;
        slave_sh = slave_sh << 1;
        MISO = SS_n ? 1'b0 : slave_sh[15];
      end
      if (!p_ss && SS_n) begin
        if (frame_n < 64) begin
          rise_c[frame_n] = cyc;
          nrise[frame_n] = rises;
        end
        if (frame_n % 2 == 0) begin
          if (frame_n / 2 < 32) cmd_w[frame_n / 2] = mosi_sh;
          last_ch = mosi_sh[13:11];
        end
        frame_n++;
        MISO = 1'b0;
      end
      if (!SS_n && !SCLK) lo_run++;
      if (SCLK) hi_run++;
      if (SS_n && MOSI !== 1'b0) mosi_bad++;
      if (regs !== p_regs && !conv_done) stray++;
      if (conv_done) begin
        if (p_done) done_long++;
        if (done_n < 32) begin
          done_c[done_n] = cyc;
          pre_s[done_n] = p_regs;
          post_s[done_n] = regs;
        end
        done_n++;
      end
    end
    p_ss = SS_n; p_sclk = SCLK; p_mosi = MOSI; p_done = conv_done; p_regs = regs;
  end

  task automatic test_reset();
    int n;
    logic hi;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (SS_n !== 1'b1) begin failures++; $display("FAIL reset_ss_n got=%b want=1", SS_n); end
    checks++; if (SCLK !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b want=0", SCLK); end
    checks++; if (MOSI !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b want=0", MOSI); end
    checks++; if (conv_done !== 1'b0) begin
      failures++; $display("FAIL reset_conv_done got=%b want=0", conv_done);
    end
    checks++; if (regs !== 48'h0) begin failures++; $display("FAIL reset_results got=%h want=0", regs); end
    n = 0;
    hi = 1'b1;
    while (hi && n < P + 10) begin
      @(posedge clk); #1;
      if (SS_n) n++;
      else hi = 1'b0;
    end
    checks++; if (n != P) begin failures++; $display("FAIL first_start_delay got=%0d want=%0d", n, P); end
  endtask

  task automatic test_reset_mid();
    int t, r;
    logic ps;
    t = 0;
    while (!(frame_n == 1 && !SS_n) && t < 2000) begin @(posedge clk); #1; t++; end
    checks++; if (t >= 2000) begin failures++; $display("FAIL frame2_timeout got=%0d want<2000", t); end
    r = 0; t = 0; ps = SCLK;
    while (r < 8 && t < 1000) begin
      @(posedge clk); #1; t++;
      if (SCLK && !ps) r++;
      ps = SCLK;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (SS_n !== 1'b1) begin failures++; $display("FAIL abort_ss_n got=%b want=1", SS_n); end
    checks++; if (SCLK !== 1'b0) begin failures++; $display("FAIL abort_sclk got=%b want=0", SCLK); end
    checks++; if (MOSI !== 1'b0) begin failures++; $display("FAIL abort_mosi got=%b want=0", MOSI); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (batt !== 12'h000) begin failures++; $display("FAIL abort_batt got=%h want=000", batt); end
  endtask

  task automatic test_command_encoding();
    logic [15:0] exp_cmd [5] = '{16'h0000, 16'h0800, 16'h1800, 16'h2000, 16'h0000};
    int t;
    t = 0;
    while (done_n < 5 && t < 6 * P) begin @(posedge clk); #1; t++; end
    checks++; if (done_n < 5) begin failures++; $display("FAIL cmd_timeout got=%0d want=5", done_n); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (cmd_w[k] !== exp_cmd[k]) begin
        failures++; $display("FAIL cmd_word[%0d] got=%h want=%h", k, cmd_w[k], exp_cmd[k]);
      end
    end
  endtask

  task automatic test_result_routing();
    logic [47:0] exp_s [5] = '{48'hABC_000_000_000, 48'hABC_123_000_000, 48'hABC_123_ABC_000,
                               48'hABC_123_ABC_FFF, 48'hABC_123_ABC_FFF};
    logic [47:0] prev;
    for (int k = 0; k < 5; k++) begin
      prev = (k == 0) ? 48'h0 : exp_s[k - 1];
      checks++;
      if (post_s[k] !== exp_s[k]) begin
        failures++; $display("FAIL route_post[%0d] got=%h want=%h", k, post_s[k], exp_s[k]);
      end
      checks++;
      if (pre_s[k] !== prev) begin
        failures++; $display("FAIL route_pre[%0d] got=%h want=%h", k, pre_s[k], prev);
      end
    end
    checks++; if (done_long != 0) begin failures++; $display("FAIL done_width got=%0d want=0", done_long); end
    checks++; if (stray != 0) begin failures++; $display("FAIL stray_update got=%0d want=0", stray); end
  endtask

  task automatic test_spi_waveform();
    checks++; if (sclk_bad != 0) begin failures++; $display("FAIL sclk_phase got=%0d want=0", sclk_bad); end
    checks++; if (mosi_bad != 0) begin failures++; $display("FAIL mosi_stable got=%0d want=0", mosi_bad); end
    for (int f = 0; f < 10; f++) begin
      checks++;
      if (rise_c[f] - fall_c[f] != 16 * DIV) begin
        failures++; $display("FAIL ss_low[%0d] got=%0d want=%0d", f, rise_c[f] - fall_c[f], 16 * DIV);
      end
      checks++;
      if (nrise[f] != 16) begin failures++; $display("FAIL sclk_rises[%0d] got=%0d want=16", f, nrise[f]); end
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (fall_c[2 * k + 1] - rise_c[2 * k] != DIV) begin
        failures++;
        $display("FAIL gap[%0d] got=%0d want=%0d", k, fall_c[2 * k + 1] - rise_c[2 * k], DIV);
      end
    end
    checks++;
    if (done_c[0] - fall_c[0] != 33 * DIV + 1) begin
      failures++; $display("FAIL latency got=%0d want=%0d", done_c[0] - fall_c[0], 33 * DIV + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] chs [4] = '{3'd0, 3'd1, 3'd3, 3'd4};
    int t;
    t = 0;
    while (done_n < 16 && t < 12 * P) begin @(posedge clk); #1; t++; end
    checks++; if (done_n < 16) begin failures++; $display("FAIL b2b_timeout got=%0d want=16", done_n); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (cmd_w[k][13:11] !== chs[k % 4]) begin
        failures++; $display("FAIL slot_seq[%0d] got=%0d want=%0d", k, cmd_w[k][13:11], chs[k % 4]);
      end
      checks++;
      if (rise_c[2 * k + 1] - fall_c[2 * k] >= P) begin
        failures++; $display("FAIL boundary[%0d] got=%0d want<%0d", k, rise_c[2 * k + 1] - fall_c[2 * k], P);
      end
      if (k > 0) begin
        checks++;
        if (fall_c[2 * k] - fall_c[2 * k - 2] != P) begin
          failures++; $display("FAIL spacing[%0d] got=%0d want=%0d", k, fall_c[2 * k] - fall_c[2 * k - 2], P);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_command_encoding();
    test_result_routing();
    test_spi_waveform();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
